// File: rtl/chacha_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit ChaCha control/key registers, one outstanding txn per direction.
// Latency: AW+W handshake at edge N -> register/BVALID/pulse at N+1; AR at edge N -> RDATA/RVALID at N+1.
// Backpressure: AW/W stall while buffered or BVALID pending; AR stalls while RVALID pending. Option: CHACHA_AXIL_SLVERR_EN.
module chacha_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [3:0]                      reg_wr_pulse
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Ready outputs stay low until the first edge after reset release.
    logic          ready_en_q, ready_en_d;

    logic          aw_held_q,  aw_held_d;
    logic [AW-1:0] aw_addr_q,  aw_addr_d;
    logic          w_held_q,   w_held_d;
    logic [DW-1:0] w_data_q,   w_data_d;
    logic [NB-1:0] w_strb_q,   w_strb_d;
    logic          bvalid_q,   bvalid_d;
    logic [1:0]    bresp_q,    bresp_d;

    logic          ar_held_q,  ar_held_d;
    logic [AW-1:0] ar_addr_q,  ar_addr_d;
    logic          rvalid_q,   rvalid_d;
    logic [1:0]    rresp_q,    rresp_d;
    logic [DW-1:0] rdata_q,    rdata_d;

    logic [DW-1:0] reg_q [4];
    logic [DW-1:0] reg_d [4];
    logic [3:0]    wr_pulse_q, wr_pulse_d;

    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [1:0]    wr_idx, rd_idx;
    logic          wr_bad, rd_bad;

    assign wr_idx = aw_addr_q[3:2];
    assign rd_idx = ar_addr_q[3:2];

`ifdef CHACHA_AXIL_SLVERR_EN
    assign wr_bad = |aw_addr_q[AW-1:4];
    assign rd_bad = |ar_addr_q[AW-1:4];
`else
    // Upper address bits ignored: the register file aliases every 16 bytes.
    assign wr_bad = 1'b0;
    assign rd_bad = 1'b0;
`endif

    assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = ready_en_q && !w_held_q  && !bvalid_q;
    assign S_AXI_ARREADY = ready_en_q && !ar_held_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign slv_reg0      = reg_q[0];
    assign slv_reg1      = reg_q[1];
    assign slv_reg2      = reg_q[2];
    assign slv_reg3      = reg_q[3];
    assign reg_wr_pulse  = wr_pulse_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign b_hs   = bvalid_q      && S_AXI_BREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs   = rvalid_q      && S_AXI_RREADY;
    assign commit = aw_held_q     && w_held_q;

    always_comb begin
        ready_en_d = 1'b1;
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            reg_d[r] = reg_q[r];
        end

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        if (b_hs) begin
            bvalid_d = 1'b0;
        end

        // Ready is low whenever a buffer is full, so commit never overlaps a new handshake.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (wr_bad) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d            = RESP_OKAY;
                wr_pulse_d[wr_idx] = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (w_strb_q[b]) begin
                        reg_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        ar_held_d = ar_held_q;
        ar_addr_d = ar_addr_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (ar_hs) begin
            ar_held_d = 1'b1;
            ar_addr_d = S_AXI_ARADDR;
        end

        if (r_hs) begin
            rvalid_d = 1'b0;
        end

        // Uses reg_q, so a write committing on this same edge is not observed.
        if (ar_held_q) begin
            ar_held_d = 1'b0;
            rvalid_d  = 1'b1;
            if (rd_bad) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = reg_q[rd_idx];
                rresp_d = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            ar_held_q  <= 1'b0;
            ar_addr_q  <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            wr_pulse_q <= 4'b0000;
            for (int r = 0; r < 4; r++) begin
                reg_q[r] <= '0;
            end
        end else begin
            ready_en_q <= ready_en_d;
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ar_held_q  <= ar_held_d;
            ar_addr_q  <= ar_addr_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            for (int r = 0; r < 4; r++) begin
                reg_q[r] <= reg_d[r];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         aw_addr_q[AW-1:4], aw_addr_q[1:0],
                         ar_addr_q[AW-1:4], ar_addr_q[1:0]};

endmodule
